// File: rtl/pool_if.sv
// Pool RAM port bundle: read side into the conv_1 map, write side into the pooled map.
interface pool_if;
    logic [14:0] poor_addrb;
    logic        poor_doutb;
    logic [12:0] pool_addra;
    logic        pool_dina;
    logic        pool_wea;

    modport master (
        output poor_addrb,
        input  poor_doutb,
        output pool_addra,
        output pool_dina,
        output pool_wea
    );

    modport slave (
        input  poor_addrb,
        output poor_doutb,
        input  pool_addra,
        input  pool_dina,
        input  pool_wea
    );
endinterface

// File: rtl/pool_1.sv
// 2x2 binary max-pool (OR of four taps) over CH maps of IN_W x IN_W, 6 cycles per output.
// Optional macro POOL1_ONES_CNT_EN adds the ones_cnt output counting written 1 pixels.
//
// state  | meaning
// S_IDLE | waiting for a conv1_over rising edge
// S_RD   | 4 cycles, issue taps (2r,2c) (2r,2c+1) (2r+1,2c) (2r+1,2c+1)
// S_CAP  | absorb tap-3 data, load write port
// S_WR   | write pulse, advance pcol/prow/ch
// S_DONE | pass complete, pool1_over held
module pool_1 #(
    parameter int CH   = 6,
    parameter int IN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        conv1_over,
    pool_if.master      bus,
    output logic        pool1_start,
    output logic        pool1_over
`ifdef POOL1_ONES_CNT_EN
    ,
    output logic [12:0] ones_cnt
`endif
);
    localparam int LOG_W = $clog2(IN_W);
    localparam int LOG_P = LOG_W - 1;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t           r_state;
    logic [CH_W-1:0]  r_ch;
    logic [LOG_P-1:0] r_prow;
    logic [LOG_P-1:0] r_pcol;
    logic [1:0]       r_tap;
    logic             r_acc;
    logic             r_conv_d;
    logic             r_armed;
    logic [14:0]      r_rd_addr;
    logic [12:0]      r_wr_addr;
    logic             r_dina;
    logic             r_wea;
    logic             r_start;
    logic             r_over;
`ifdef POOL1_ONES_CNT_EN
    logic [12:0]      r_ones_cnt;
`endif

    logic             w_start;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_last_ch;
    logic             w_last;
    logic [CH_W-1:0]  w_nxt_ch;
    logic [LOG_P-1:0] w_nxt_prow;
    logic [LOG_P-1:0] w_nxt_pcol;

    function automatic logic [14:0] f_rd_addr(input logic [CH_W-1:0] ch,
                                              input logic [LOG_P-1:0] prow,
                                              input logic [LOG_P-1:0] pcol,
                                              input logic [1:0] tap);
        logic [31:0] a;
        a = (32'(ch) << (2 * LOG_W)) | (32'({prow, tap[1]}) << LOG_W) | 32'({pcol, tap[0]});
        return a[14:0];
    endfunction

    function automatic logic [12:0] f_wr_addr(input logic [CH_W-1:0] ch,
                                              input logic [LOG_P-1:0] prow,
                                              input logic [LOG_P-1:0] pcol);
        logic [31:0] a;
        a = (32'(ch) << (2 * LOG_P)) | (32'(prow) << LOG_P) | 32'(pcol);
        return a[12:0];
    endfunction

    // r_armed keeps a level held high through reset release from looking like an edge
    assign w_start    = conv1_over & ~r_conv_d & r_armed;
    assign w_last_col = (r_pcol == {LOG_P{1'b1}});
    assign w_last_row = (r_prow == {LOG_P{1'b1}});
    assign w_last_ch  = (r_ch == CH_W'(CH - 1));
    assign w_last     = w_last_col & w_last_row & w_last_ch;

    always_comb begin
        w_nxt_pcol = r_pcol + 1'b1;
        w_nxt_prow = r_prow;
        w_nxt_ch   = r_ch;
        if (w_last_col) begin
            w_nxt_prow = r_prow + 1'b1;
            if (w_last_row) begin
                w_nxt_ch = r_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_prow     <= '0;
            r_pcol     <= '0;
            r_tap      <= '0;
            r_acc      <= 1'b0;
            r_conv_d   <= 1'b0;
            r_armed    <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_dina     <= 1'b0;
            r_wea      <= 1'b0;
            r_start    <= 1'b0;
            r_over     <= 1'b0;
`ifdef POOL1_ONES_CNT_EN
            r_ones_cnt <= '0;
`endif
        end else begin
            r_conv_d <= conv1_over;
            r_armed  <= 1'b1;
            r_wea    <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state   <= S_RD;
                        r_start   <= 1'b1;
                        r_over    <= 1'b0;
                        r_ch      <= '0;
                        r_prow    <= '0;
                        r_pcol    <= '0;
                        r_tap     <= '0;
                        r_rd_addr <= '0;
`ifdef POOL1_ONES_CNT_EN
                        r_ones_cnt <= '0;
`endif
                    end
                end
                S_RD: begin
                    // data arriving during tap 0 belongs to the previous window
                    if (r_tap == 2'd0) begin
                        r_acc <= 1'b0;
                    end else begin
                        r_acc <= r_acc | bus.poor_doutb;
                    end
                    r_tap <= r_tap + 2'd1;
                    if (r_tap == 2'd3) begin
                        r_state <= S_CAP;
                    end else begin
                        r_rd_addr <= f_rd_addr(r_ch, r_prow, r_pcol, r_tap + 2'd1);
                    end
                end
                S_CAP: begin
                    r_acc     <= r_acc | bus.poor_doutb;
                    r_dina    <= r_acc | bus.poor_doutb;
                    r_wr_addr <= f_wr_addr(r_ch, r_prow, r_pcol);
                    r_wea     <= 1'b1;
                    r_state   <= S_WR;
                end
                S_WR: begin
`ifdef POOL1_ONES_CNT_EN
                    if (r_dina) begin
                        r_ones_cnt <= r_ones_cnt + 13'd1;
                    end
`endif
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_start <= 1'b0;
                        r_over  <= 1'b1;
                    end else begin
                        r_state   <= S_RD;
                        r_ch      <= w_nxt_ch;
                        r_prow    <= w_nxt_prow;
                        r_pcol    <= w_nxt_pcol;
                        r_tap     <= '0;
                        r_rd_addr <= f_rd_addr(w_nxt_ch, w_nxt_prow, w_nxt_pcol, 2'd0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.poor_addrb = r_rd_addr;
    assign bus.pool_addra = r_wr_addr;
    assign bus.pool_dina  = r_dina;
    assign bus.pool_wea   = r_wea;
    assign pool1_start    = r_start;
    assign pool1_over     = r_over;
`ifdef POOL1_ONES_CNT_EN
    assign ones_cnt       = r_ones_cnt;
`endif
endmodule

// File: tb/tb_pool_1.sv
// Bench for pool_1 at a reduced geometry (CH=3, IN_W=16) so every scenario fits a short run;
// expected writes come from a 2x2-OR model computed directly over the bench's RAM image.
module tb_pool_1;
    localparam int CH    = 3;
    localparam int IN_W  = 16;
    localparam int PW    = IN_W / 2;
    localparam int N_IN  = CH * IN_W * IN_W;
    localparam int P_PIX = CH * PW * PW;
    localparam int P_CYC = 6 * P_PIX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic conv1_over = 1'b0;
    logic pool1_start;
    logic pool1_over;
`ifdef POOL1_ONES_CNT_EN
    logic [12:0] ones_cnt;
`endif

    pool_if ram_if ();

    pool_1 #(.CH(CH), .IN_W(IN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .conv1_over (conv1_over),
        .bus        (ram_if.master),
        .pool1_start(pool1_start),
        .pool1_over (pool1_over)
`ifdef POOL1_ONES_CNT_EN
        ,
        .ones_cnt   (ones_cnt)
`endif
    );

    always #5 clk = ~clk;

    bit ram [N_IN];
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_if.poor_doutb <= (int'(ram_if.poor_addrb) < N_IN) ? ram[ram_if.poor_addrb] : 1'b0;
    end

    // reference write stream
    int exp_addr [P_PIX];
    bit exp_dat  [P_PIX];
    int wr_base = 0;

    // cumulative monitor state, owned by the monitor only
    int wr_total = 0, ones_total = 0, mis_total = 0, pulse_err = 0;
    int last_one_addr = -1;
    int tap_seen [4];
    int tap_n = 0;
    bit prev_wea = 0, prev_start = 0;

    always @(negedge clk) begin
        int idx;
        if (pool1_start && !prev_start) tap_n = 0;
        if (pool1_start && tap_n < 4) begin
            tap_seen[tap_n] = int'(ram_if.poor_addrb);
            tap_n++;
        end
        if (ram_if.pool_wea) begin
            idx = wr_total - wr_base;
            if (idx < 0 || idx >= P_PIX) mis_total++;
            else if (int'(ram_if.pool_addra) != exp_addr[idx] || ram_if.pool_dina != exp_dat[idx]) mis_total++;
            if (prev_wea) pulse_err++;
            if (ram_if.pool_dina) begin
                ones_total++;
                last_one_addr = int'(ram_if.pool_addra);
            end
            wr_total++;
        end
        prev_wea   = ram_if.pool_wea;
        prev_start = pool1_start;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < N_IN; i++) begin
            case (kind)
                0: ram[i] = 1'b0;
                1: ram[i] = 1'b1;
                2: ram[i] = (i == IN_W * IN_W + IN_W + 1);
                3: ram[i] = ($urandom_range(0, 15) == 0);
                default: ram[i] = ($urandom_range(0, 9) < 3);
            endcase
        end
    endtask

    function automatic int build_model();
        int ones = 0;
        for (int c = 0; c < CH; c++)
            for (int pr = 0; pr < PW; pr++)
                for (int pc = 0; pc < PW; pc++) begin
                    int k = c * PW * PW + pr * PW + pc;
                    int b = c * IN_W * IN_W + 2 * pr * IN_W + 2 * pc;
                    exp_addr[k] = k;
                    exp_dat[k]  = ram[b] | ram[b + 1] | ram[b + IN_W] | ram[b + IN_W + 1];
                    if (exp_dat[k]) ones++;
                end
        return ones;
    endfunction

    task automatic edge_and_wait_start(output int t0, output bit seen);
        int n = 0;
        @(negedge clk) conv1_over = 1'b0;
        @(negedge clk) conv1_over = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!pool1_start && n < 10);
        seen = pool1_start;
        t0 = cyc;
    endtask

    task automatic do_pass(input string nm, input int exp_ones, input bit mid_edge, input bit single);
        int t0, t1, n, w0, o0, m0, p0, model_ones;
        bit seen;
        model_ones = build_model();
        wr_base = wr_total;
        w0 = wr_total; o0 = ones_total; m0 = mis_total; p0 = pulse_err;
        edge_and_wait_start(t0, seen);
        chk({nm, ".start_seen"}, seen, 1);
        chk({nm, ".over_cleared"}, pool1_over, 0);
        if (mid_edge) begin
            repeat (100) @(negedge clk);
            conv1_over = 1'b0;
            @(negedge clk) conv1_over = 1'b1;
        end
        n = 0;
        while (!pool1_over && n < 2 * P_CYC) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        chk({nm, ".over_seen"}, pool1_over, 1);
        chk({nm, ".pass_cycles"}, t1 - t0, P_CYC);
        chk({nm, ".writes"}, wr_total - w0, P_PIX);
        chk({nm, ".seq_mismatches"}, mis_total - m0, 0);
        chk({nm, ".wea_pulse_errs"}, pulse_err - p0, 0);
        chk({nm, ".ones"}, ones_total - o0, (exp_ones >= 0) ? exp_ones : model_ones);
        chk({nm, ".tap0"}, tap_seen[0], 0);
        chk({nm, ".tap1"}, tap_seen[1], 1);
        chk({nm, ".tap2"}, tap_seen[2], IN_W);
        chk({nm, ".tap3"}, tap_seen[3], IN_W + 1);
        repeat (3) @(negedge clk);
        chk({nm, ".done_start"}, pool1_start, 0);
        chk({nm, ".done_wea"}, ram_if.pool_wea, 0);
        chk({nm, ".done_over"}, pool1_over, 1);
`ifdef POOL1_ONES_CNT_EN
        chk({nm, ".ones_cnt"}, ones_cnt, (exp_ones >= 0) ? exp_ones : model_ones);
`endif
        if (single) chk({nm, ".single_addr"}, last_one_addr, PW * PW);
    endtask

    typedef struct {
        string name;
        int    kind;
        int    exp_ones;   // -1: take from the model
        bit    mid_edge;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int t0, w0;
        bit seen;
        vecs[0] = '{"all_zero",   0, 0,     1'b0};
        vecs[1] = '{"all_one",    1, P_PIX, 1'b0};
        vecs[2] = '{"single_px",  2, 1,     1'b0};
        vecs[3] = '{"rand_sparse",3, -1,    1'b0};
        vecs[4] = '{"rand_dense", 4, -1,    1'b1};

        repeat (3) @(negedge clk);
        chk("rst.poor_addrb", ram_if.poor_addrb, 0);
        chk("rst.pool_addra", ram_if.pool_addra, 0);
        chk("rst.pool_dina", ram_if.pool_dina, 0);
        chk("rst.pool_wea", ram_if.pool_wea, 0);
        chk("rst.start", pool1_start, 0);
        chk("rst.over", pool1_over, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].kind);
            do_pass(vecs[v].name, vecs[v].exp_ones, vecs[v].mid_edge, vecs[v].kind == 2);
        end

        // reset mid-pass with conv1_over held high through release
        fill(4);
        void'(build_model());
        wr_base = wr_total;
        edge_and_wait_start(t0, seen);
        chk("mid_rst.start_seen", seen, 1);
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst.poor_addrb", ram_if.poor_addrb, 0);
        chk("mid_rst.pool_addra", ram_if.pool_addra, 0);
        chk("mid_rst.pool_wea", ram_if.pool_wea, 0);
        chk("mid_rst.pool_dina", ram_if.pool_dina, 0);
        chk("mid_rst.start", pool1_start, 0);
        chk("mid_rst.over", pool1_over, 0);
        rst = 1'b0;
        w0 = wr_total;
        repeat (50) @(negedge clk);
        chk("mid_rst.no_writes", wr_total - w0, 0);
        chk("mid_rst.held_no_start", pool1_start, 0);
        chk("mid_rst.held_no_over", pool1_over, 0);

        fill(3);
        do_pass("post_rst", -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pool_1.md
POOL_1 -- requirements
Module: pool_1

Interface
REQ-001 SHALL have parameter CH, default 6, number of feature-map channels.
REQ-002 SHALL have parameter IN_W, default 64, input map width and height in pixels (square, power of two).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port conv1_over  input  1  level from conv_1; its rising edge starts a pooling pass.
REQ-006 SHALL have port poor_addrb  output  15  read address into pool RAM written by conv_1; address = ch*IN_W*IN_W + row*IN_W + col.
REQ-007 SHALL have port poor_doutb  input  1  binary pixel; valid exactly one cycle after poor_addrb.
REQ-008 SHALL have port pool_addra  output  13  write address of pooled map; address = ch*(IN_W/2)^2 + prow*(IN_W/2) + pcol.
REQ-009 SHALL have port pool_dina  output  1  pooled pixel.
REQ-010 SHALL have port pool_wea  output  1  write enable, one-cycle pulse per pooled pixel.
REQ-011 SHALL have port pool1_start  output  1  high while a pass is in progress.
REQ-012 SHALL have port pool1_over  output  1  high from pass completion until the next start or reset.

Function
REQ-013 SHALL detect conv1_over rising edge via a registered copy; edge in IDLE or DONE starts a pass; edges while busy are ignored.
REQ-014 SHALL use FSM states IDLE, RD, CAP, WR, DONE.
REQ-015 IDLE/DONE -> RD on start edge; pool1_over cleared, pool1_start set in the same cycle the FSM enters RD.
REQ-016 RD SHALL last 4 cycles, issuing taps (2r,2c),(2r,2c+1),(2r+1,2c),(2r+1,2c+1) of the current channel in that order, one per cycle.
REQ-017 Accumulator SHALL be cleared at tap 0 issue and OR-ed with poor_doutb each cycle data returns (2x2 max of binary data = OR).
REQ-018 CAP SHALL last 1 cycle, absorbing tap-3 data.
REQ-019 WR SHALL last 1 cycle: pool_wea=1, pool_dina=accumulated OR, pool_addra=current pooled address.
REQ-020 After WR, counters SHALL advance pcol, then prow, then ch; on wrap of last ch (ch=CH-1, prow=pcol=IN_W/2-1) FSM -> DONE, else -> RD.
REQ-021 Throughput SHALL be exactly 6 cycles per pooled pixel; full pass with defaults = 6*32*32*6 = 36864 cycles from RD entry to DONE entry.
REQ-022 In DONE: pool1_start=0, pool1_over=1, pool_wea=0, held until next start edge or reset.
REQ-023 pool_wea SHALL be 0 in every state other than WR.
REQ-024 Address arithmetic SHALL be unsigned, zero-extended; channel offset formed by shift (IN_W power of two).

Reset
REQ-025 On rst=1 at a clock edge: FSM -> IDLE; all counters, accumulator, edge register = 0; poor_addrb=0, pool_addra=0, pool_dina=0, pool_wea=0, pool1_start=0, pool1_over=0.
REQ-026 Reset mid-pass SHALL abort with no further writes; a new conv1_over rising edge after reset restarts from address 0.
REQ-027 conv1_over held high through reset release SHALL NOT start a pass (edge register reset to 0 then loads 1 without edge... edge register SHALL load conv1_over on the first post-reset cycle with start suppressed in that cycle).

Configuration
REQ-028 Macro POOL1_ONES_CNT_EN defined: SHALL add output ones_cnt  output  13, counting WR cycles with pool_dina=1, cleared at reset and at pass start, stable in DONE.
REQ-029 Macro undefined: port ones_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 RAM all 0, conv1_over 0->1 -> 6144 pool_wea pulses, all pool_dina=0, pool1_over rises 36864 cycles after pool1_start; ones_cnt=0.
REQ-031 RAM all 1 -> every pool_dina=1, last write pool_addra=6143; ones_cnt=6144.
REQ-032 Single 1 at poor address 4096+65 (ch1,row1,col1) -> only pool_addra=1024 written with 1; ones_cnt=1.
REQ-033 rst asserted at cycle 10000 of a pass -> pool_wea stays 0 thereafter, all outputs 0; next conv1_over edge gives full 6144-write pass.
REQ-034 Second conv1_over edge at cycle 500 of a pass -> ignored, pass still ends at cycle 36864 with 6144 writes.
REQ-035 Checker: pool_addra sequence strictly 0..6143 incrementing by 1, and poor_addrb tap order per REQ-016 for first output (0,1,64,65).
